// File: rtl/pe_pkg.sv
// Shared PE-array definitions: default activation width, scratchpad depth
// and the helper that sizes scratchpad pointers.
package pe_pkg;

  localparam int PE_DATA_W = 8;
  localparam int PE_DEPTH  = 16;

  function automatic int aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [aw(PE_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/spad_ram.sv
// Scratchpad storage: one synchronous write port and one synchronous read port.
// Only the read output register is clearable; the array itself is never reset.
module spad_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register holds its value between reads so rd_data stays stable.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ifmap_spad.sv
// Input-activation scratchpad: circular buffer of ifmap activations with a
// sliding filter window (base + offset) read by the PE controller.
module ifmap_spad
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int DEPTH  = PE_DEPTH,
  parameter int WIN    = 5,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              stop_read,
  output logic              win_full,
  input  logic              win_reset,
  input  logic              stride_adv,
  output logic              err
);

  localparam int AW = aw(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] WIN_C    = CW'(WIN);
  localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] offset_q, offset_d;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;

  logic          wr_fire;
  logic          rd_fire;
  logic [CW-1:0] step_s;
  logic [CW-1:0] wr_inc;
  logic [AW-1:0] rd_addr;

  // Flags come straight from the registered counters, no lookahead.
  assign in_ready  = (count_q != DEPTH_C);
  assign stop_read = (offset_q == count_q);
  assign win_full  = (count_q >= WIN_C);
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign rd_addr   = base_q + offset_q[AW-1:0];

  always_comb begin
    wr_fire    = in_valid & in_ready & ~flush;
    rd_fire    = rd_en & ~stop_read & ~flush & ~stride_adv & ~win_reset;
    step_s     = (count_q < STRIDE_C) ? count_q : STRIDE_C;
    wr_inc     = {{(CW-1){1'b0}}, wr_fire};

    wr_ptr_d   = wr_ptr_q;
    base_d     = base_q;
    count_d    = count_q;
    offset_d   = offset_q;
    rd_valid_d = rd_fire;
    err_d      = err_q;

    if (flush) begin
      wr_ptr_d = '0;
      base_d   = '0;
      count_d  = '0;
      offset_d = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      // Advance releases at most what is resident; under-run is flagged, not blocked.
      if (stride_adv) begin
        base_d   = base_q + step_s[AW-1:0];
        count_d  = count_q + wr_inc - step_s;
        offset_d = '0;
        if (count_q < STRIDE_C) begin
          err_d = 1'b1;
        end
      end else begin
        count_d = count_q + wr_inc;
        if (win_reset) begin
          offset_d = '0;
        end else if (rd_fire) begin
          offset_d = offset_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      base_q     <= '0;
      count_q    <= '0;
      offset_q   <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      base_q     <= base_d;
      count_q    <= count_d;
      offset_q   <= offset_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  spad_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .clr   (rst | flush),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .re    (rd_fire),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_ifmap_spad.sv
// Randomised and directed bench for ifmap_spad against a queue-based model
// of the resident window.
module tb_ifmap_spad;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int WIN    = 5;
  localparam int STRIDE = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              stop_read;
  logic              win_full;
  logic              win_reset = 1'b0;
  logic              stride_adv = 1'b0;
  logic              err;

  ifmap_spad #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .WIN    (WIN),
    .STRIDE (STRIDE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .stop_read  (stop_read),
    .win_full   (win_full),
    .win_reset  (win_reset),
    .stride_adv (stride_adv),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Model: resident entries in order from the window base, plus read offset.
  logic [DATA_W-1:0] mq[$];
  int                m_off;
  logic              m_err;
  logic              m_rv;
  logic [DATA_W-1:0] m_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_off = 0;
    m_err = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    $display("reset");
  endtask

  // One clock of stimulus: flags checked before the edge, registers after.
  task automatic step(input logic fl, input logic iv, input logic [DATA_W-1:0] d,
                      input logic re, input logic wrs, input logic adv);
    int  pre_size;
    int  s;
    logic rdy;
    flush = fl; in_valid = iv; in_data = d; rd_en = re; win_reset = wrs; stride_adv = adv;
    #1;
    pre_size = mq.size();
    rdy = (pre_size != DEPTH);
    chk("in_ready",  int'(in_ready),  int'(rdy));
    chk("stop_read", int'(stop_read), int'(m_off == pre_size));
    chk("win_full",  int'(win_full),  int'(pre_size >= WIN));
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_off = 0;
      m_rv  = 1'b0;
      m_rd  = '0;
    end else begin
      m_rv = re && !adv && !wrs && (m_off < pre_size);
      if (m_rv) begin
        m_rd = mq[m_off];
        m_off++;
      end
      if (adv) begin
        s = (pre_size < STRIDE) ? pre_size : STRIDE;
        if (pre_size < STRIDE) m_err = 1'b1;
        for (int i = 0; i < s; i++) void'(mq.pop_front());
        m_off = 0;
      end else if (wrs) begin
        m_off = 0;
      end
      if (iv && rdy) mq.push_back(d);
    end
    #1;
    chk("rd_valid", int'(rd_valid), int'(m_rv));
    chk("rd_data",  int'(rd_data),  int'(m_rd));
    chk("err",      int'(err),      int'(m_err));
    $display("txn fl=%0b iv=%0b d=%02h re=%0b wrs=%0b adv=%0b | rv=%0b rd=%02h rdy=%0b sr=%0b wf=%0b err=%0b cnt=%0d",
             fl, iv, d, re, wrs, adv, rd_valid, rd_data, in_ready, stop_read, win_full, err, mq.size());
    flush = 1'b0; in_valid = 1'b0; rd_en = 1'b0; win_reset = 1'b0; stride_adv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt;
    int iter;
    logic iv, re, wrs, adv;

    model_reset();
    do_reset();
    #1;
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_stop_read", int'(stop_read), 1);
    chk("rst_win_full",  int'(win_full),  0);
    chk("rst_rd_valid",  int'(rd_valid),  0);
    chk("rst_rd_data",   int'(rd_data),   0);
    chk("rst_err",       int'(err),       0);

    // Fill one window
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    // Read it out, plus one read past the end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // Rewind, re-read, advance, read
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("adv_read_val", int'(rd_data), 8'h11);
    // Read coinciding with advance is dropped
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Fill to full, try an extra write, then advance with a write
    iter = 0;
    while (mq.size() < DEPTH && iter < 100) begin
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      iter++;
    end
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("full_adv_ready", int'(in_ready), 1);

    // Flush with a write pending, then randomised wrap traffic
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    wr_cnt = 0;
    iter   = 0;
    while (wr_cnt < 40 && iter < 3000) begin
      iv  = ($urandom_range(0, 99) < 55);
      re  = ($urandom_range(0, 99) < 60);
      wrs = ($urandom_range(0, 99) < 5);
      adv = (mq.size() >= STRIDE) && ($urandom_range(0, 99) < 20);
      if (iv && mq.size() != DEPTH) wr_cnt++;
      step(1'b0, iv, 8'($urandom_range(0, 255)), re, wrs, adv);
      iter++;
    end
    chk("wrap_writes", wr_cnt, 40);
    chk("wrap_err", int'(err), 0);

    // Under-run advance, flush keeps err, reset clears it
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("underrun_err", int'(err), 1);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("underrun_base", int'(rd_data), 8'h55);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("flush_err_sticky", int'(err), 1);
    do_reset();
    #1;
    chk("rst_err_clear", int'(err), 0);
    chk("rst_stop_read2", int'(stop_read), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
